// File: rtl/life_frame_sequencer.sv
// 8x8 Game of Life generation sequencer.
// Ping-pong grid buffers, seed stream load, tear-free pixel read port.
module life_frame_sequencer #(
  parameter logic [7:0] ALIVE_VALUE = 8'hFF,
  parameter logic [7:0] DEAD_VALUE  = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        seed_valid,
  input  logic [7:0]  seed_data,
  output logic        seed_ready,
  input  logic        step,
  input  logic [5:0]  pix_addr,
  output logic [7:0]  pix_data,
  output logic        busy,
  output logic        gen_done,
  output logic [15:0] generation,
  output logic [6:0]  alive_count
);

  typedef enum logic [2:0] {
    IDLE, LOAD, READY, COMPUTE, SWAP
  } state_t;

  state_t state, state_nx;

  logic [1:0][63:0] bufs;
  logic [63:0]      front;
  logic             front_sel;
  logic [5:0]       idx;
  logic [6:0]       pop;
  logic [2:0]       row, col;
  logic [3:0]       nbr;
  logic             cur, nxt;
  logic             xfer, seed_bit, last;

  assign front      = bufs[front_sel];
  assign seed_ready = (state == LOAD);
  assign busy       = (state == LOAD) ||
                      (state == COMPUTE) ||
                      (state == SWAP);
  assign xfer       = seed_valid && seed_ready;
  assign seed_bit   = |seed_data;
  assign last       = (idx == 6'd63);
  assign row        = idx[5:3];
  assign col        = idx[2:0];
  assign cur        = front[idx];

  // Toroidal neighbour count and next-cell rule for the current index
  always_comb begin
    nbr = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (dr != 0 || dc != 0) begin
          nbr = nbr + 4'(front[{3'(row + dr),
                                 3'(col + dc)}]);
        end
      end
    end
    nxt = cur ? (nbr == 4'd2 || nbr == 4'd3)
              : (nbr == 4'd3);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; load has priority over step in READY
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (load) state_nx = LOAD;
      LOAD:    if (xfer && last) state_nx = READY;
      READY: begin
        if (load)      state_nx = LOAD;
        else if (step) state_nx = COMPUTE;
      end
      COMPUTE: if (last) state_nx = SWAP;
      SWAP:    state_nx = READY;
      default: state_nx = IDLE;
    endcase
  end

  // Grid buffers, counters, status and registered pixel port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bufs        <= '0;
      front_sel   <= 1'b0;
      idx         <= '0;
      pop         <= '0;
      pix_data    <= 8'h00;
      gen_done    <= 1'b0;
      generation  <= '0;
      alive_count <= '0;
    end else begin
      gen_done <= 1'b0;
      pix_data <= front[pix_addr] ? ALIVE_VALUE
                                  : DEAD_VALUE;
      unique case (state)
        IDLE: begin
          if (load) begin
            idx <= '0;
            pop <= '0;
          end
        end
        READY: begin
          if (load || step) begin
            idx <= '0;
            pop <= '0;
          end
        end
        LOAD: begin
          if (xfer) begin
            bufs[front_sel][idx] <= seed_bit;
            idx <= idx + 6'd1;
            pop <= pop + 7'(seed_bit);
            if (last) begin
              generation  <= '0;
              alive_count <= pop + 7'(seed_bit);
            end
          end
        end
        COMPUTE: begin
          bufs[~front_sel][idx] <= nxt;
          idx <= idx + 6'd1;
          pop <= pop + 7'(nxt);
        end
        SWAP: begin
          front_sel   <= ~front_sel;
          alive_count <= pop;
          generation  <= generation + 16'd1;
          gen_done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
